// File: rtl/tile_sequencer.sv
// Tile sequencer: for each column tile, preloads the ifmap (PE_SIZE cycles), then
// streams WEIGHT_ROW_NUM weight rows gated by weight_valid_i; pulses done_o after the last tile.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start_i          start pulse, sampled only while idle
//   clear_i          synchronous abort back to idle
//   weight_valid_i   weight FIFO has a row this cycle
//   ifmap_load_o     preload strobe; ifmap_addr_o is the preload row
//   weight_rd_en_o   FIFO pop; weight_addr_o is the current weight row
//   tile_idx_o       current column tile
//   psum_en_o        psum-valid enable, identical to weight_rd_en_o
//   busy_o           not idle
//   done_o           one-cycle completion pulse
module tile_sequencer #(
  parameter int PE_SIZE        = 14,
  parameter int WEIGHT_ROW_NUM = 70,
  parameter int WEIGHT_COL_NUM = 294
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic clear_i,
  input  logic weight_valid_i,
  output logic ifmap_load_o,
  output logic [$clog2(PE_SIZE)-1:0] ifmap_addr_o,
  output logic weight_rd_en_o,
  output logic [$clog2(WEIGHT_ROW_NUM)-1:0] weight_addr_o,
  output logic [$clog2(WEIGHT_COL_NUM/PE_SIZE)-1:0] tile_idx_o,
  output logic psum_en_o,
  output logic busy_o,
  output logic done_o
);

  localparam int TILE_NUM = WEIGHT_COL_NUM / PE_SIZE;
  localparam int IW = $clog2(PE_SIZE);
  localparam int WW = $clog2(WEIGHT_ROW_NUM);
  localparam int TW = $clog2(TILE_NUM);

  localparam logic [IW-1:0] I_LAST = IW'(PE_SIZE - 1);
  localparam logic [WW-1:0] W_LAST = WW'(WEIGHT_ROW_NUM - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TILE_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRELOAD,
    S_STREAM,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0] icnt_q, icnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic accept;

  // A row is consumed only while streaming and the FIFO has data;
  // this single term gates every counter advance in STREAM.
  assign accept = (state_q == S_STREAM) & weight_valid_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      icnt_q  <= '0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;

    if (clear_i) begin
      state_d = S_IDLE;
      icnt_d  = '0;
      wcnt_d  = '0;
      tcnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_PRELOAD;
            icnt_d  = '0;
            wcnt_d  = '0;
            tcnt_d  = '0;
          end
        end
        S_PRELOAD: begin
          if (icnt_q == I_LAST) begin
            state_d = S_STREAM;
            icnt_d  = '0;
            wcnt_d  = '0;
          end else begin
            icnt_d = icnt_q + 1'b1;
          end
        end
        S_STREAM: begin
          if (accept) begin
            if (wcnt_q == W_LAST) begin
              wcnt_d = '0;
              icnt_d = '0;
              // Last tile holds its index through DONE.
              if (tcnt_q == T_LAST) begin
                state_d = S_DONE;
              end else begin
                state_d = S_PRELOAD;
                tcnt_d  = tcnt_q + 1'b1;
              end
            end else begin
              wcnt_d = wcnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          icnt_d  = '0;
          wcnt_d  = '0;
          tcnt_d  = '0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from state so an async reset
  // zeroes them without waiting for a clock edge.
  assign ifmap_load_o   = (state_q == S_PRELOAD);
  assign ifmap_addr_o   = icnt_q;
  assign weight_rd_en_o = accept;
  assign psum_en_o      = accept;
  assign weight_addr_o  = wcnt_q;
  assign tile_idx_o     = tcnt_q;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE);

endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer with a progress-count reference model
// checked every cycle, plus literal expectations for latency and boundaries.
module tb_tile_sequencer;

  localparam int P   = 14;
  localparam int R   = 70;
  localparam int C   = 294;
  localparam int TN  = C / P;
  localparam int SEG = P + R;
  localparam int TOT = TN * SEG;

  logic clk = 1'b0;
  logic rst;
  logic start_i;
  logic clear_i;
  logic weight_valid_i;
  logic ifmap_load_o;
  logic [3:0] ifmap_addr_o;
  logic weight_rd_en_o;
  logic [6:0] weight_addr_o;
  logic [4:0] tile_idx_o;
  logic psum_en_o;
  logic busy_o;
  logic done_o;

  tile_sequencer #(
    .PE_SIZE(P),
    .WEIGHT_ROW_NUM(R),
    .WEIGHT_COL_NUM(C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .clear_i(clear_i),
    .weight_valid_i(weight_valid_i),
    .ifmap_load_o(ifmap_load_o),
    .ifmap_addr_o(ifmap_addr_o),
    .weight_rd_en_o(weight_rd_en_o),
    .weight_addr_o(weight_addr_o),
    .tile_idx_o(tile_idx_o),
    .psum_en_o(psum_en_o),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is a count k of completed progress steps. Each tile
  // occupies SEG steps: P preload steps then R accepted rows. Stalled
  // stream cycles do not advance k. k==TOT is the done cycle.
  bit run = 1'b0;
  int k = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || clear_i) begin
      run <= 1'b0;
      k   <= 0;
    end else if (!run) begin
      if (start_i) begin
        run       <= 1'b1;
        k         <= 0;
        start_cyc <= cyc + 1;
      end
    end else if (k == TOT) begin
      run <= 1'b0;
      k   <= 0;
    end else if ((k % SEG) < P || weight_valid_i) begin
      k <= k + 1;
    end
  end

  int done_cnt = 0;
  int last_lat = 0;
  int load_cnt = 0;
  int psum_cnt = 0;

  always @(negedge clk) begin
    int e_load, e_iaddr, e_waddr, e_tile, e_psum, e_busy, e_done, off;
    e_load = 0; e_iaddr = 0; e_waddr = 0; e_tile = 0;
    e_psum = 0; e_busy = 0; e_done = 0;
    if (!rst && run) begin
      e_busy = 1;
      if (k == TOT) begin
        e_done = 1;
        e_tile = TN - 1;
      end else begin
        e_tile = k / SEG;
        off = k % SEG;
        if (off < P) begin
          e_load  = 1;
          e_iaddr = off;
        end else begin
          e_waddr = off - P;
          e_psum  = int'(weight_valid_i);
        end
      end
    end
    chk("ifmap_load", int'(ifmap_load_o), e_load);
    chk("ifmap_addr", int'(ifmap_addr_o), e_iaddr);
    chk("weight_addr", int'(weight_addr_o), e_waddr);
    chk("tile_idx", int'(tile_idx_o), e_tile);
    chk("psum_en", int'(psum_en_o), e_psum);
    chk("rd_en", int'(weight_rd_en_o), e_psum);
    chk("busy", int'(busy_o), e_busy);
    chk("done", int'(done_o), e_done);
    if (ifmap_load_o) load_cnt++;
    if (psum_en_o) psum_cnt++;
    if (done_o) begin
      done_cnt++;
      last_lat = cyc - start_cyc;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #2 start_i = 1'b1;
    @(posedge clk); #2 start_i = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    forever begin
      @(negedge clk); #1;
      if (done_o) break;
      n++;
      if (n > lim) begin
        chk("wait_done_timeout", 0, 1);
        break;
      end
    end
  endtask

  // Stop mid-cycle at a given tile and preload/stream address.
  task automatic wait_pos(input int t, input bit pre, input int a);
    int n;
    bit hit;
    n = 0;
    forever begin
      @(negedge clk); #1;
      if (pre)
        hit = ifmap_load_o && int'(ifmap_addr_o) == a;
      else
        hit = busy_o && !ifmap_load_o && !done_o &&
              int'(weight_addr_o) == a;
      if (hit && int'(tile_idx_o) == t) break;
      n++;
      if (n > 3000) begin
        chk("wait_pos_timeout", 0, 1);
        break;
      end
    end
  endtask

  initial begin
    int dc;
    rst = 1'b1;
    start_i = 1'b0;
    clear_i = 1'b0;
    weight_valid_i = 1'b1;
    #1;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_tile", int'(tile_idx_o), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Nominal run
    load_cnt = 0;
    psum_cnt = 0;
    pulse_start();
    chk("first_load", int'(ifmap_load_o), 1);
    chk("first_iaddr", int'(ifmap_addr_o), 0);
    wait_done(2000);
    chk("nom_latency", last_lat, 1764);
    chk("nom_load_cycles", load_cnt, 294);
    chk("nom_psum_cycles", psum_cnt, 1470);
    chk("done_tile", int'(tile_idx_o), 20);
    @(negedge clk); #1;
    chk("post_done", int'(done_o), 0);
    chk("post_busy", int'(busy_o), 0);
    chk("post_tile", int'(tile_idx_o), 0);

    // Stall five cycles at row 30 of tile 3
    pulse_start();
    wait_pos(3, 1'b0, 30);
    weight_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #3;
      chk("stall_addr", int'(weight_addr_o), 30);
      chk("stall_psum", int'(psum_en_o), 0);
    end
    weight_valid_i = 1'b1;
    wait_done(2000);
    chk("stall_latency", last_lat, 1769);

    // start_i while busy is ignored
    pulse_start();
    wait_pos(5, 1'b0, 10);
    @(posedge clk); #2 start_i = 1'b1;
    @(posedge clk); #2 start_i = 1'b0;
    chk("ign_addr", int'(weight_addr_o), 12);
    chk("ign_tile", int'(tile_idx_o), 5);
    wait_done(2000);
    chk("ign_latency", last_lat, 1764);

    // clear_i during preload of tile 2
    pulse_start();
    wait_pos(2, 1'b1, 5);
    dc = done_cnt;
    clear_i = 1'b1;
    @(posedge clk); #2 clear_i = 1'b0;
    chk("clr_busy", int'(busy_o), 0);
    chk("clr_load", int'(ifmap_load_o), 0);
    chk("clr_tile", int'(tile_idx_o), 0);
    chk("clr_iaddr", int'(ifmap_addr_o), 0);
    repeat (20) @(posedge clk);
    #2;
    chk("clr_no_done", done_cnt, dc);
    pulse_start();
    chk("restart_tile", int'(tile_idx_o), 0);
    chk("restart_load", int'(ifmap_load_o), 1);
    wait_done(2000);
    chk("restart_latency", last_lat, 1764);

    // Async reset mid-stream
    pulse_start();
    wait_pos(1, 1'b0, 7);
    dc = done_cnt;
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_psum", int'(psum_en_o), 0);
    chk("arst_rd", int'(weight_rd_en_o), 0);
    chk("arst_waddr", int'(weight_addr_o), 0);
    chk("arst_tile", int'(tile_idx_o), 0);
    @(posedge clk); #2 rst = 1'b0;
    chk("arst_rel_busy", int'(busy_o), 0);
    repeat (30) @(posedge clk);
    #2;
    chk("arst_idle", int'(busy_o), 0);
    chk("arst_no_done", done_cnt, dc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tile_sequencer.md
TILE_SEQUENCER -- requirements
Module: tile_sequencer

Interface
REQ-001 SHALL have parameter PE_SIZE, default 14: systolic array edge length; ifmap preload length in cycles.
REQ-002 SHALL have parameter WEIGHT_ROW_NUM, default 70: weight rows streamed per tile.
REQ-003 SHALL have parameter WEIGHT_COL_NUM, default 294: total weight columns; must be an integer multiple of PE_SIZE.
REQ-004 SHALL derive local constant TILE_NUM = WEIGHT_COL_NUM/PE_SIZE (21 at defaults).
REQ-005 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start_i  input  1  one-cycle pulse starting a layer run; sampled only in IDLE.
REQ-008 SHALL have port clear_i  input  1  synchronous abort; returns the FSM to IDLE.
REQ-009 SHALL have port weight_valid_i  input  1  weight FIFO holds a row this cycle.
REQ-010 SHALL have port ifmap_load_o  output  1  ifmap preload strobe.
REQ-011 SHALL have port ifmap_addr_o  output  $clog2(PE_SIZE)  preload row index.
REQ-012 SHALL have port weight_rd_en_o  output  1  weight FIFO pop.
REQ-013 SHALL have port weight_addr_o  output  $clog2(WEIGHT_ROW_NUM)  current weight row index.
REQ-014 SHALL have port tile_idx_o  output  $clog2(TILE_NUM)  current column tile.
REQ-015 SHALL have port psum_en_o  output  1  psum-valid enable to the downstream accumulation counter.
REQ-016 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-017 SHALL have port done_o  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, PRELOAD, STREAM, DONE.
REQ-019 SHALL transition IDLE->PRELOAD on the edge where start_i=1; start_i in any other state SHALL be ignored.
REQ-020 SHALL hold PRELOAD for exactly PE_SIZE cycles with no stall; ifmap_load_o=1 and ifmap_addr_o counting 0..PE_SIZE-1.
REQ-021 SHALL transition PRELOAD->STREAM on the edge after ifmap_addr_o=PE_SIZE-1; weight_addr_o SHALL be 0 on STREAM entry.
REQ-022 SHALL drive weight_rd_en_o = psum_en_o = (state==STREAM) & weight_valid_i, combinationally.
REQ-023 SHALL increment weight_addr_o only on cycles where psum_en_o=1; weight_valid_i=0 SHALL stall all counters.
REQ-024 SHALL, on an accepted row with weight_addr_o=WEIGHT_ROW_NUM-1: increment tile_idx_o and go to PRELOAD if tile_idx_o<TILE_NUM-1, otherwise go to DONE.
REQ-025 SHALL assert done_o for exactly the one cycle spent in DONE, then return to IDLE; tile_idx_o SHALL clear to 0 on the DONE->IDLE edge.
REQ-026 SHALL clear all counters to 0 on every PRELOAD entry except tile_idx_o.
REQ-027 SHALL give clear_i priority over start_i and all state advances; the next state is IDLE, all counters are 0 and done_o is not pulsed.
REQ-028 SHALL hold ifmap_load_o, weight_rd_en_o, psum_en_o and done_o at 0 outside their respective states.
REQ-029 SHALL take TILE_NUM*(PE_SIZE+WEIGHT_ROW_NUM) cycles from the start_i edge to DONE entry with weight_valid_i held high (1764 at defaults).
REQ-030 SHALL produce per tile a pattern of PE_SIZE psum_en_o-low cycles followed by WEIGHT_ROW_NUM accepted psum_en_o-high cycles.

Reset
REQ-031 SHALL, while rst=1, immediately force state IDLE and all outputs and counters to 0, independent of clk.
REQ-032 SHALL, on rst assertion mid-run, abandon the run with no done_o; after release the block SHALL await a new start_i.

Verification
REQ-033 SHALL verify nominal run at defaults with weight_valid_i=1: start_i pulse -> 21 tiles of 14 ifmap_load_o cycles plus 70 psum_en_o cycles; done_o at cycle 1764 after start; busy_o low the following cycle.
REQ-034 SHALL verify stall: weight_valid_i=0 for 5 cycles at weight_addr_o=30 in tile 3 -> weight_addr_o holds 30, psum_en_o=0, total latency 1769.
REQ-035 SHALL verify last-row boundary: accepted row 69 of tile 20 -> DONE, done_o=1 for one cycle, tile_idx_o=0 afterwards.
REQ-036 SHALL verify start_i ignored while busy: a pulse during STREAM of tile 5 -> no counter change, latency unchanged.
REQ-037 SHALL verify clear_i during PRELOAD of tile 2 -> IDLE next cycle, all outputs 0, no done_o; a new start_i restarts at tile 0.
REQ-038 SHALL verify asynchronous rst asserted between edges during STREAM -> outputs 0 before the next edge; busy_o=0 after release.
